// File: rtl/segre_pkg.sv
// segre_pkg: shared memory-op types and sizes for the segre store buffer.
package segre_pkg;
    localparam int NUM_SB_ENTRIES = 4;
    localparam int ADDR_SIZE      = 32;
    localparam int WORD_SIZE      = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memop_data_type_e;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        memop_data_type_e     data_type;
    } sb_entry_t;
endpackage

// File: rtl/segre_sb_byte_mask.sv
// segre_sb_byte_mask: byte lanes touched by an aligned access within its word.
module segre_sb_byte_mask
    import segre_pkg::*;
(
    input  memop_data_type_e type_i,
    input  logic [1:0]       offset_i,
    output logic [3:0]       mask_o
);
    always_comb mask_o = (type_i == BYTE) ? (4'b0001 << offset_i) :
                         (type_i == HALF) ? (4'b0011 << offset_i) : 4'b1111;
endmodule

// File: rtl/segre_store_buffer.sv
// segre_store_buffer: circular store FIFO between MEM stage and dcache with
// same-cycle store-to-load forwarding and partial-overlap conflict detection.
module segre_store_buffer
    import segre_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_SB_ENTRIES,
    parameter int ADDR_W      = ADDR_SIZE,
    parameter int DATA_W      = WORD_SIZE
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  memop_data_type_e  push_type_i,
    output logic              full_o,
    output logic              empty_o,
    input  logic              ld_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  memop_data_type_e  ld_type_i,
    output logic              ld_hit_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_conflict_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              drain_valid_o,
    output logic [ADDR_W-1:0] drain_addr_o,
    output logic [DATA_W-1:0] drain_data_o,
    output memop_data_type_e  drain_type_o,
    input  logic              drain_ready_i
);
    localparam int PW = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [PW:0]            count_q, count_d;
    logic [ADDR_W-1:0]      addr_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    memop_data_type_e       type_q [NUM_ENTRIES];
    logic [3:0]             mask_q [NUM_ENTRIES];
    logic [3:0]             push_mask, ld_mask;
    logic [DATA_W-1:0]      ld_size_mask;
    logic [PW-1:0]          idx, young;
    logic                   push_ok, drain_ok, found, exact;

    segre_sb_byte_mask u_push_mask (.type_i(push_type_i), .offset_i(push_addr_i[1:0]), .mask_o(push_mask));
    segre_sb_byte_mask u_ld_mask   (.type_i(ld_type_i),   .offset_i(ld_addr_i[1:0]),   .mask_o(ld_mask));

    assign full_o        = count_q == (PW+1)'(NUM_ENTRIES);
    assign empty_o       = count_q == '0;
    assign drain_valid_o = !empty_o && !hold_i && !flush_i;
    assign drain_addr_o  = addr_q[head_q];
    assign drain_data_o  = data_q[head_q];
    assign drain_type_o  = type_q[head_q];
    assign push_ok       = push_i && !full_o && !flush_i;
    assign drain_ok      = drain_valid_o && drain_ready_i;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(drain_ok);
        if (drain_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push_ok) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
            type_q[tail_q] <= push_type_i;
            mask_q[tail_q] <= push_mask;
        end
    end

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        found = 1'b0;
        young = head_q;
        idx   = head_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2] && |(mask_q[idx] & ld_mask)) begin
                found = 1'b1;
                young = idx;
            end
        end
        exact = found && addr_q[young][1:0] == ld_addr_i[1:0] && type_q[young] == ld_type_i;
    end

    assign ld_size_mask  = (ld_type_i == BYTE) ? 32'h0000_00FF :
                           (ld_type_i == HALF) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    assign ld_hit_o      = ld_i && exact;
    assign ld_conflict_o = ld_i && found && !exact;
    assign ld_data_o     = ld_hit_o ? (data_q[young] & ld_size_mask) : '0;
endmodule

// File: tb/tb_segre_store_buffer.sv
// tb_segre_store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_segre_store_buffer;
    import segre_pkg::*;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             push_i = 1'b0, ld_i = 1'b0, hold_i = 1'b0, flush_i = 1'b0, drain_ready_i = 1'b0;
    logic [31:0]      push_addr_i = '0, push_data_i = '0, ld_addr_i = '0;
    memop_data_type_e push_type_i = WORD, ld_type_i = WORD;
    logic             full_o, empty_o, ld_hit_o, ld_conflict_o, drain_valid_o;
    logic [31:0]      ld_data_o, drain_addr_o, drain_data_o;
    memop_data_type_e drain_type_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      d;
        memop_data_type_e t;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    segre_store_buffer dut (
        .clk_i(clk), .rst_i(rst_i),
        .push_i(push_i), .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_type_i(push_type_i),
        .full_o(full_o), .empty_o(empty_o),
        .ld_i(ld_i), .ld_addr_i(ld_addr_i), .ld_type_i(ld_type_i),
        .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o), .ld_conflict_o(ld_conflict_o),
        .hold_i(hold_i), .flush_i(flush_i),
        .drain_valid_o(drain_valid_o), .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o),
        .drain_type_o(drain_type_o), .drain_ready_i(drain_ready_i)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic longint nbytes(input memop_data_type_e t);
        return (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
    endfunction

    // Reference: byte-interval overlap against the youngest store in the queue.
    initial begin
        logic        e_hit, e_conf, e_dv;
        logic [31:0] e_data;
        int          n;
        forever begin
            @(negedge clk);
            #4;
            if (rst_i) begin
                chk("rst_full", full_o, 0);
                chk("rst_empty", empty_o, 1);
                chk("rst_dv", drain_valid_o, 0);
                chk("rst_hit", ld_hit_o, 0);
                chk("rst_conf", ld_conflict_o, 0);
                e_dv = 1'b0;
            end else begin
                e_hit = 1'b0; e_conf = 1'b0; e_data = '0;
                if (ld_i) begin
                    for (int i = q.size() - 1; i >= 0; i--) begin
                        if (longint'(q[i].a) < longint'(ld_addr_i) + nbytes(ld_type_i) &&
                            longint'(ld_addr_i) < longint'(q[i].a) + nbytes(q[i].t)) begin
                            if (q[i].a == ld_addr_i && q[i].t == ld_type_i) begin
                                e_hit  = 1'b1;
                                e_data = 32'((64'(q[i].d)) & ((64'd1 << (8 * nbytes(ld_type_i))) - 1));
                            end else e_conf = 1'b1;
                            break;
                        end
                    end
                end
                e_dv = q.size() > 0 && !hold_i && !flush_i;
                chk("full", full_o, q.size() == 4);
                chk("empty", empty_o, q.size() == 0);
                chk("drain_valid", drain_valid_o, e_dv);
                chk("ld_hit", ld_hit_o, e_hit);
                chk("ld_conflict", ld_conflict_o, e_conf);
                chk("ld_data", ld_data_o, e_data);
                if (e_dv) begin
                    chk("drain_addr", drain_addr_o, q[0].a);
                    chk("drain_data", drain_data_o, q[0].d);
                    chk("drain_type", drain_type_o, q[0].t);
                end
            end
            @(posedge clk);
            if (rst_i || flush_i) q.delete();
            else begin
                n = q.size();
                if (e_dv && drain_ready_i) q.delete(0);
                if (push_i && n < 4) q.push_back('{push_addr_i, push_data_i, push_type_i});
            end
        end
    end

    task automatic nx();
        @(negedge clk);
        push_i = 1'b0; ld_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic psh(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
        push_i = 1'b1; push_addr_i = a; push_data_i = d; push_type_i = t;
    endtask

    task automatic lde(input logic [31:0] a, input memop_data_type_e t);
        ld_i = 1'b1; ld_addr_i = a; ld_type_i = t;
    endtask

    initial begin
        memop_data_type_e t;
        logic [1:0]       off;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        hold_i = 1'b1;
        nx(); psh(32'h100, 32'hDEADBEEF, WORD);
        nx(); lde(32'h100, WORD); #4;
        chk("lit_word_hit", ld_hit_o, 1);
        chk("lit_word_data", ld_data_o, 32'hDEADBEEF);
        nx(); psh(32'h101, 32'hAA, BYTE);
        nx(); lde(32'h100, WORD); #4;
        chk("lit_partial_conf", ld_conflict_o, 1);
        chk("lit_partial_hit", ld_hit_o, 0);
        nx(); hold_i = 1'b0; flush_i = 1'b1; psh(32'h500, 32'h55, WORD);
        nx(); #4;
        chk("lit_flush_empty", empty_o, 1);
        chk("lit_flush_dv", drain_valid_o, 0);
        hold_i = 1'b1;
        nx(); psh(32'h200, 32'd1, WORD);
        nx(); psh(32'h200, 32'd2, WORD);
        nx(); lde(32'h200, WORD); #4;
        chk("lit_youngest_data", ld_data_o, 32'd2);
        nx(); hold_i = 1'b0; drain_ready_i = 1'b1; #4;
        chk("lit_drain_first", drain_data_o, 32'd1);
        nx(); #4;
        chk("lit_drain_second", drain_data_o, 32'd2);
        nx(); #4;
        chk("lit_drained_empty", empty_o, 1);
        hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nx(); psh(32'h300 + 32'(4 * i), 32'h10 + 32'(i), WORD);
        end
        nx(); psh(32'h310, 32'h99, WORD); #4;
        chk("lit_full", full_o, 1);
        nx(); hold_i = 1'b0; #4;
        chk("lit_full_after_drop", full_o, 1);
        chk("lit_order0", drain_data_o, 32'h10);
        for (int i = 1; i < 4; i++) begin
            nx(); #4;
            chk("lit_order", drain_data_o, 32'h10 + 32'(i));
        end
        nx(); #4;
        chk("lit_order_empty", empty_o, 1);
        nx(); flush_i = 1'b1; hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nx(); psh(32'h600 + 32'(4 * i), 32'hA0 + 32'(i), WORD);
        end
        nx(); hold_i = 1'b0; psh(32'h60C, 32'hA3, WORD); #4;
        chk("lit_c3_head", drain_data_o, 32'hA0);
        nx(); hold_i = 1'b1; psh(32'h610, 32'hA4, WORD); #4;
        chk("lit_c3_not_full", full_o, 0);
        chk("lit_c3_not_empty", empty_o, 0);
        nx(); #4;
        chk("lit_wrap_full", full_o, 1);
        hold_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("lit_wrap_order", drain_data_o, 32'hA0 + 32'(i));
            nx(); #3;
        end
        hold_i = 1'b1;
        nx(); psh(32'h700, 32'hB0, WORD);
        nx(); psh(32'h704, 32'hB1, WORD);
        nx(); hold_i = 1'b0; drain_ready_i = 1'b0; #4;
        chk("lit_offer_dv", drain_valid_o, 1);
        nx(); #4;
        chk("lit_offer_stable", drain_data_o, 32'hB0);
        nx(); drain_ready_i = 1'b1; #2; rst_i = 1'b1; #1;
        chk("lit_async_dv", drain_valid_o, 0);
        chk("lit_async_empty", empty_o, 1);
        nx(); rst_i = 1'b0; #4;
        chk("lit_after_rst_empty", empty_o, 1);
        for (int c = 0; c < 3000; c++) begin
            nx();
            hold_i = $urandom_range(0, 4) == 0;
            flush_i = $urandom_range(0, 49) == 0;
            drain_ready_i = $urandom_range(0, 9) < 6;
            t = memop_data_type_e'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            off = (t == BYTE) ? off : (t == HALF) ? {off[1], 1'b0} : 2'b00;
            push_i = $urandom_range(0, 1);
            push_type_i = t;
            push_addr_i = 32'h400 + 32'(4 * $urandom_range(0, 3)) + 32'(off);
            push_data_i = $urandom;
            t = memop_data_type_e'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            off = (t == BYTE) ? off : (t == HALF) ? {off[1], 1'b0} : 2'b00;
            ld_i = $urandom_range(0, 3) != 0;
            ld_type_i = t;
            ld_addr_i = 32'h400 + 32'(4 * $urandom_range(0, 3)) + 32'(off);
        end
        nx();
        nx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
